// File: rtl/level_mem_arbiter.sv
// Tile-map read arbiter shared by the display fetcher and the collision engine.
// Three-cycle read pipeline with fixed display priority and collision anti-starvation.
module level_mem_arbiter #(
    parameter int         MAP_W        = 40,
    parameter int         MAP_H        = 30,
    parameter int         TILE_SHIFT   = 4,
    parameter int         STARVE_LIMIT = 8,
    parameter logic [2:0] BLK_OOB      = 3'd7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        disp_req,
    input  logic [9:0]  disp_x,
    input  logic [9:0]  disp_y,
    output logic [2:0]  disp_data,
    output logic        disp_valid,
    input  logic        col_req,
    input  logic [9:0]  col_x,
    input  logic [9:0]  col_y,
    output logic [2:0]  col_data,
    output logic        col_ack,
    output logic [10:0] mem_addr,
    input  logic [2:0]  mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_BUSY = 2'd2;

    logic [1:0]       r_col_state;
    logic [CNT_W-1:0] r_starve;
    logic             r_pend_v;
    logic [9:0]       r_pend_x;
    logic [9:0]       r_pend_y;
    logic             r_t1_v, r_t1_col, r_t1_oob;
    logic             r_t2_v, r_t2_col, r_t2_oob;
    logic [10:0]      r_mem_addr;
    logic [2:0]       r_disp_data;
    logic [2:0]       r_col_data;
    logic             r_disp_valid;
    logic             r_col_ack;

    logic        w_dv;
    logic [9:0]  w_dx, w_dy;
    logic        w_col_cand, w_starved, w_col_win, w_disp_win, w_issue;
    logic [9:0]  w_sel_x, w_sel_y;
    logic [10:0] w_tile_col, w_tile_row, w_addr;
    logic        w_oob;

    // A fresh disp_req always supersedes whatever is parked in the pending slot.
    assign w_dv       = disp_req | r_pend_v;
    assign w_dx       = disp_req ? disp_x : r_pend_x;
    assign w_dy       = disp_req ? disp_y : r_pend_y;
    assign w_col_cand = (r_col_state == C_WAIT) && col_req;
    assign w_starved  = (r_starve >= CNT_W'(STARVE_LIMIT));
    assign w_col_win  = w_col_cand && (!w_dv || w_starved);
    assign w_disp_win = w_dv && !w_col_win;
    assign w_issue    = w_col_win | w_disp_win;

    assign w_sel_x    = w_col_win ? col_x : w_dx;
    assign w_sel_y    = w_col_win ? col_y : w_dy;
    assign w_tile_col = 11'(w_sel_x >> TILE_SHIFT);
    assign w_tile_row = 11'(w_sel_y >> TILE_SHIFT);
    assign w_oob      = (w_tile_col >= 11'(MAP_W)) || (w_tile_row >= 11'(MAP_H));
    assign w_addr     = w_tile_row * 11'(MAP_W) + w_tile_col;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_col_state <= C_IDLE;
            r_starve    <= '0;
        end else begin
            case (r_col_state)
                // The ack cycle itself is ignored so one held request yields one ack.
                C_IDLE: if (col_req && !r_col_ack) r_col_state <= C_WAIT;
                C_WAIT: begin
                    if (!col_req)       r_col_state <= C_IDLE;
                    else if (w_col_win) r_col_state <= C_BUSY;
                end
                C_BUSY: if (r_t2_v && r_t2_col) r_col_state <= C_IDLE;
                default: r_col_state <= C_IDLE;
            endcase
            if (w_col_cand && !w_col_win) r_starve <= r_starve + 1'b1;
            else                          r_starve <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend_v <= 1'b0;
            r_pend_x <= '0;
            r_pend_y <= '0;
        end else if (w_dv && w_col_win) begin
            r_pend_v <= 1'b1;
            r_pend_x <= w_dx;
            r_pend_y <= w_dy;
        end else begin
            r_pend_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_t1_v       <= 1'b0;
            r_t1_col     <= 1'b0;
            r_t1_oob     <= 1'b0;
            r_t2_v       <= 1'b0;
            r_t2_col     <= 1'b0;
            r_t2_oob     <= 1'b0;
            r_mem_addr   <= '0;
            r_disp_data  <= '0;
            r_col_data   <= '0;
            r_disp_valid <= 1'b0;
            r_col_ack    <= 1'b0;
        end else begin
            r_t1_v   <= w_issue;
            r_t1_col <= w_col_win;
            r_t1_oob <= w_oob;
            r_t2_v   <= r_t1_v;
            r_t2_col <= r_t1_col;
            r_t2_oob <= r_t1_oob;
            if (w_issue && !w_oob) r_mem_addr <= w_addr;
            r_disp_valid <= r_t2_v && !r_t2_col;
            r_col_ack    <= r_t2_v && r_t2_col;
            if (r_t2_v && !r_t2_col) r_disp_data <= r_t2_oob ? BLK_OOB : mem_rdata;
            if (r_t2_v && r_t2_col)  r_col_data  <= r_t2_oob ? BLK_OOB : mem_rdata;
        end
    end

    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign col_data   = r_col_data;
    assign col_ack    = r_col_ack;
    assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_level_mem_arbiter.sv
// Directed bench for level_mem_arbiter with a one-cycle synchronous tile-map model.
module tb_level_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        disp_req;
    logic [9:0]  disp_x, disp_y;
    logic [2:0]  disp_data;
    logic        disp_valid;
    logic        col_req;
    logic [9:0]  col_x, col_y;
    logic [2:0]  col_data;
    logic        col_ack;
    logic [10:0] mem_addr;
    logic [2:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int n_dv = 0;
    int n_ca = 0;
    int base_dv, base_ca;

    level_mem_arbiter #(
        .MAP_W(40), .MAP_H(30), .TILE_SHIFT(4), .STARVE_LIMIT(8), .BLK_OOB(3'd7)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .col_req(col_req), .col_x(col_x), .col_y(col_y),
        .col_data(col_data), .col_ack(col_ack),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map contents: addr[2:0] ^ addr[5:3] ^ 1, so 42->6, 41->5, 1199->3, 102->3, 10->2, 3->2, 0->1.
    function automatic logic [2:0] mem_fn(input logic [10:0] a);
        return a[2:0] ^ a[5:3] ^ 3'd1;
    endfunction

    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

    always @(negedge clk) begin
        if (disp_valid === 1'b1) n_dv++;
        if (col_ack === 1'b1)    n_ca++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        disp_req = 1'b0; disp_x = '0; disp_y = '0;
        col_req  = 1'b0; col_x  = '0; col_y  = '0;
        step(); step();
        check("rst_disp_data", disp_data, 0);
        check("rst_col_data", col_data, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_col_ack", col_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        step();

        // Display fetch at (35,20) -> tile (2,1) -> addr 42
        base_dv = n_dv;
        disp_req = 1'b1; disp_x = 10'd35; disp_y = 10'd20;
        step();
        disp_req = 1'b0;
        check("a_addr", mem_addr, 42);
        check("a_valid_k", disp_valid, 0);
        step();
        check("a_valid_k1", disp_valid, 0);
        step();
        check("a_valid", disp_valid, 1);
        check("a_data", disp_data, 6);
        step();
        check("a_valid_off", disp_valid, 0);
        check("a_hold", disp_data, 6);
        check("a_count", n_dv - base_dv, 1);

        // Collision at the last on-map pixel -> addr 1199; req held through the ack cycle
        base_ca = n_ca;
        col_req = 1'b1; col_x = 10'd639; col_y = 10'd479;
        step();
        check("b_wait_addr", mem_addr, 42);
        step();
        check("b_addr", mem_addr, 1199);
        step(); step();
        check("b_ack", col_ack, 1);
        check("b_data", col_data, 3);
        step();
        check("b_ack_off", col_ack, 0);
        check("b_state", dut.r_col_state, 0);
        col_req = 1'b0;
        step(); step();
        check("b_once", n_ca - base_ca, 1);
        check("b_state_idle", dut.r_col_state, 0);

        // Off-map collision x=640: BLK_OOB at normal latency, mem_addr untouched
        col_req = 1'b1; col_x = 10'd640; col_y = 10'd0;
        step(); step();
        check("c_addr", mem_addr, 1199);
        step();
        check("c_ack_early", col_ack, 0);
        step();
        check("c_ack", col_ack, 1);
        check("c_data", col_data, 7);
        step();
        col_req = 1'b0;
        step();

        // Simultaneous requests: display (addr 41) first, collision (addr 0) next cycle
        disp_req = 1'b1; disp_x = 10'd16; disp_y = 10'd16;
        col_req  = 1'b1; col_x  = 10'd0;  col_y  = 10'd0;
        step();
        disp_req = 1'b0;
        check("d_addr_disp", mem_addr, 41);
        step();
        check("d_addr_col", mem_addr, 0);
        step();
        check("d_disp_valid", disp_valid, 1);
        check("d_disp_data", disp_data, 5);
        check("d_ack_early", col_ack, 0);
        step();
        check("d_ack", col_ack, 1);
        check("d_col_data", col_data, 1);
        check("d_valid_off", disp_valid, 0);
        step();
        col_req = 1'b0;
        step();

        // Display every cycle with collision (addr 102) held: forced grant on 9th waiting cycle
        base_dv = n_dv; base_ca = n_ca;
        col_req = 1'b1; col_x = 10'd352; col_y = 10'd32;
        for (int i = 0; i <= 10; i++) begin
            disp_req = 1'b1; disp_x = 10'(16 * i); disp_y = 10'd0;
            step();
            if (i == 9) check("e_starve_grant", mem_addr, 102);
            else        check("e_disp_addr", mem_addr, i);
        end
        disp_req = 1'b0;
        step();
        check("e_ack", col_ack, 1);
        check("e_col_data", col_data, 3);
        step();
        col_req = 1'b0;
        step();
        check("e_disp_count", n_dv - base_dv, 10);
        check("e_ack_count", n_ca - base_ca, 1);
        check("e_last_data", disp_data, 2);

        // col_req dropped while waiting: no read, back to idle, no ack
        base_ca = n_ca;
        col_req = 1'b1; col_x = 10'd80; col_y = 10'd0;
        step();
        col_req = 1'b0;
        step();
        check("g_addr", mem_addr, 10);
        check("g_state", dut.r_col_state, 0);
        step(); step();
        check("g_no_ack", n_ca - base_ca, 0);

        // col_req dropped while busy: still completes (addr 3)
        col_req = 1'b1; col_x = 10'd48; col_y = 10'd0;
        step(); step();
        col_req = 1'b0;
        check("h_addr", mem_addr, 3);
        step(); step();
        check("h_ack", col_ack, 1);
        check("h_data", col_data, 2);
        step();
        check("h_state", dut.r_col_state, 0);

        // Reset with a display and a collision read both in flight
        disp_req = 1'b1; disp_x = 10'd35; disp_y = 10'd20;
        col_req  = 1'b1; col_x  = 10'd48; col_y  = 10'd0;
        step();
        disp_req = 1'b0;
        step();
        col_req = 1'b0;
        reset_n = 1'b0;
        base_dv = n_dv; base_ca = n_ca;
        step();
        check("r_disp_data", disp_data, 0);
        check("r_col_data", col_data, 0);
        check("r_disp_valid", disp_valid, 0);
        check("r_col_ack", col_ack, 0);
        check("r_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("r_no_disp", n_dv - base_dv, 0);
        check("r_no_ack", n_ca - base_ca, 0);
        check("r_state", dut.r_col_state, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
